// File: rtl/jtag_pkg.sv
// Shared types and bit positions for the JTAG vector player: FSM states,
// vector byte fields, result byte fields and a result byte packer.
package jtag_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      LOW,
      HIGH,
      WRITE,
      DONE
   } state_t;

   localparam int VEC_TMS = 0;
   localparam int VEC_TDI = 1;
   localparam int VEC_CAP = 2;
   localparam int VEC_EXP = 3;

   localparam int RES_TDO = 0;
   localparam int RES_CAP = 1;
   localparam int RES_MIS = 2;

   function automatic logic [7:0] make_result(input logic tdo_bit,
                                              input logic cap_bit,
                                              input logic mis_bit);
      logic [7:0] r;
      r          = '0;
      r[RES_TDO] = tdo_bit;
      r[RES_CAP] = cap_bit;
      r[RES_MIS] = mis_bit;
      return r;
   endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK phase generator: counts half_i clk cycles per phase, toggles TCK at the
// end of each phase and flags that last cycle with phase_end_o.
module jtag_tck_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic             run_i,
   input  logic             clear_i,
   input  logic [DIV_W-1:0] half_i,
   output logic             tck_o,
   output logic             phase_end_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tck_q, tck_d;

   assign phase_end_o = run_i && (cnt_q == '0);
   assign tck_o       = tck_q;

   // half_i is at least 1, so reloading half_i-1 yields exactly half_i cycles per phase
   always_comb begin
      cnt_d = cnt_q;
      tck_d = tck_q;
      if (clear_i) begin
         cnt_d = '0;
         tck_d = 1'b0;
      end else if (load_i) begin
         cnt_d = half_i - DIV_W'(1);
         tck_d = 1'b0;
      end else if (run_i) begin
         if (cnt_q == '0) begin
            cnt_d = half_i - DIV_W'(1);
            tck_d = ~tck_q;
         end else begin
            cnt_d = cnt_q - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

endmodule

// File: rtl/jtag_vector_player.sv
// Plays JTAG vectors from vector RAM 1 onto TCK/TMS/TDI and writes one result
// byte per vector to vector RAM 2. Define JTAG_TDO_COMPARE_EN for TDO compare.
module jtag_vector_player
   import jtag_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DIV_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   length,
   input  logic [DIV_W-1:0]  tck_half,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] vector_1_addr,
   input  logic [7:0]        vector_1_rd_data,
   output logic [ADDR_W-1:0] vector_2_addr,
   output logic              vector_2_we,
   output logic [7:0]        vector_2_wr_data,
   output logic              tck,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo,
   output logic [ADDR_W:0]   mismatch_cnt
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] last_q;
   logic [DIV_W-1:0]  half_q;
   logic              tms_q, tdi_q, cap_q;
   logic              tdo_meta_q, tdo_s_q;
   logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
   logic              we_q, busy_q, done_q;
   logic [7:0]        wr_data_q;
   logic              accept, write_entry, phase_end, mis_bit, unused_bits;
   logic [ADDR_W:0]   len_m1;

   assign accept      = (state_q == IDLE) && start && !abort;
   assign len_m1      = length - (ADDR_W+1)'(1);
   assign write_entry = (state_d == WRITE);

   jtag_tck_gen #(.DIV_W(DIV_W)) u_tck_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (state_q == WAIT),
      .run_i      ((state_q == LOW) || (state_q == HIGH)),
      .clear_i    (abort),
      .half_i     (half_q),
      .tck_o      (tck),
      .phase_end_o(phase_end)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               idx_d   = '0;
               state_d = (length != '0) ? FETCH : DONE;
            end
         end
         FETCH: state_d = WAIT;
         WAIT:  state_d = LOW;
         LOW:   if (phase_end) state_d = HIGH;
         HIGH:  if (phase_end) state_d = WRITE;
         WRITE: begin
            if (idx_q == last_q) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = FETCH;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   // Registered outputs follow the next state, so they line up with the state they belong to
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         last_q     <= '0;
         half_q     <= DIV_W'(1);
         tms_q      <= 1'b1;
         tdi_q      <= 1'b0;
         cap_q      <= 1'b0;
         tdo_meta_q <= 1'b0;
         tdo_s_q    <= 1'b0;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rd_addr_q  <= idx_d;
         tdo_meta_q <= tdo;
         tdo_s_q    <= tdo_meta_q;
         busy_q     <= state_d inside {FETCH, WAIT, LOW, HIGH, WRITE};
         done_q     <= (state_d == DONE);
         we_q       <= write_entry;
         if (accept) begin
            last_q <= len_m1[ADDR_W-1:0];
            half_q <= (tck_half == '0) ? DIV_W'(1) : tck_half;
         end
         if (state_q == WAIT && !abort) begin
            tms_q <= vector_1_rd_data[VEC_TMS];
            tdi_q <= vector_1_rd_data[VEC_TDI];
            cap_q <= vector_1_rd_data[VEC_CAP];
         end
         if (write_entry) begin
            wr_addr_q <= idx_q;
            wr_data_q <= make_result(cap_q & tdo_s_q, cap_q, mis_bit);
         end
      end
   end

`ifdef JTAG_TDO_COMPARE_EN
   logic            exp_q;
   logic [ADDR_W:0] mis_cnt_q;

   // Mismatches are counted as the result byte is formed, saturating at all-ones
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_q     <= 1'b0;
         mis_cnt_q <= '0;
      end else begin
         if (state_q == WAIT && !abort) exp_q <= vector_1_rd_data[VEC_EXP];
         if (accept) begin
            mis_cnt_q <= '0;
         end else if (write_entry && mis_bit && (mis_cnt_q != '1)) begin
            mis_cnt_q <= mis_cnt_q + (ADDR_W+1)'(1);
         end
      end
   end

   assign mis_bit      = cap_q && (tdo_s_q != exp_q);
   assign mismatch_cnt = mis_cnt_q;
   assign unused_bits  = ^{vector_1_rd_data[7:4], len_m1[ADDR_W]};
`else
   assign mis_bit      = 1'b0;
   assign mismatch_cnt = '0;
   assign unused_bits  = ^{vector_1_rd_data[7:3], len_m1[ADDR_W]};
`endif

   assign busy             = busy_q;
   assign done             = done_q;
   assign vector_1_addr    = rd_addr_q;
   assign vector_2_addr    = wr_addr_q;
   assign vector_2_we      = we_q;
   assign vector_2_wr_data = wr_data_q;
   assign tms              = tms_q;
   assign tdi              = tdi_q;

endmodule

// File: tb/tb_jtag_vector_player.sv
// Directed bench for jtag_vector_player with behavioural vector RAMs and a
// TCK/write monitor; expectations follow JTAG_TDO_COMPARE_EN when defined.
module tb_jtag_vector_player;

   localparam int ADDR_W = 12;
   localparam int DIV_W  = 16;

   logic              clk = 1'b0;
   logic              resetN, start, abort, tdo;
   logic [ADDR_W:0]   length;
   logic [DIV_W-1:0]  tckHalf;
   logic              busy, done, tck, tms, tdi, vector2We;
   logic [ADDR_W-1:0] vector1Addr, vector2Addr;
   logic [7:0]        vector1RdData, vector2WrData;
   logic [ADDR_W:0]   mismatchCnt;

   logic [7:0] ram1 [0:4095];
   logic [7:0] ram2 [0:4095];

   int errors = 0;
   int checks = 0;
   int weCount = 0, doneCount = 0, riseCount = 0, lastWrAddr = 0;
   longint wrAddrSum = 0;
   int highRun = 0, lowRun = 0;
   logic tckPrev = 1'b0;
   int highQ[$];
   int lowQ[$];
   logic tmsQ[$];
   logic tdiQ[$];

   jtag_vector_player #(.ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
      .clk             (clk),
      .reset_n         (resetN),
      .start           (start),
      .abort           (abort),
      .length          (length),
      .tck_half        (tckHalf),
      .busy            (busy),
      .done            (done),
      .vector_1_addr   (vector1Addr),
      .vector_1_rd_data(vector1RdData),
      .vector_2_addr   (vector2Addr),
      .vector_2_we     (vector2We),
      .vector_2_wr_data(vector2WrData),
      .tck             (tck),
      .tms             (tms),
      .tdi             (tdi),
      .tdo             (tdo),
      .mismatch_cnt    (mismatchCnt)
   );

   always #5 clk = ~clk;

   // Vector RAM 1 read port with one cycle of registered latency
   always @(posedge clk) vector1RdData <= ram1[vector1Addr];

   // RAM 2 write port plus TCK shape and pin monitor, sampling pre-edge values
   always @(posedge clk) begin
      if (vector2We) begin
         ram2[vector2Addr] = vector2WrData;
         weCount++;
         wrAddrSum += longint'(vector2Addr);
         lastWrAddr = int'(vector2Addr);
      end
      if (done) doneCount++;
      if (tck) begin
         if (!tckPrev) begin
            riseCount++;
            tmsQ.push_back(tms);
            tdiQ.push_back(tdi);
            lowQ.push_back(lowRun);
            highRun = 1;
         end else begin
            highRun++;
         end
      end else begin
         if (tckPrev) begin
            highQ.push_back(highRun);
            lowRun = 1;
         end else begin
            lowRun++;
         end
      end
      tckPrev = tck;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [ADDR_W:0] len, input logic [DIV_W-1:0] half);
      @(negedge clk);
      length  = len;
      tckHalf = half;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // Counts negedges after the accepting edge until done is seen
   task automatic waitDone(input int limit, output int cycles);
      cycles = 0;
      while (!done && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   initial begin
      int n, w0, r0, d0, h0, t0;
      longint s0;
      logic [3:0] expTms, expTdi;
      logic [7:0] exp2, exp3, expCmp0, expCmp1;
      int expMis1, expMis6;

`ifdef JTAG_TDO_COMPARE_EN
      exp2 = 8'h07; exp3 = 8'h07; expMis1 = 2;
      expCmp0 = 8'h06; expCmp1 = 8'h02; expMis6 = 2;
`else
      exp2 = 8'h03; exp3 = 8'h03; expMis1 = 0;
      expCmp0 = 8'h02; expCmp1 = 8'h02; expMis6 = 0;
`endif
      expTms = 4'b0101;
      expTdi = 4'b1110;

      for (int i = 0; i < 4096; i++) ram1[i] = 8'h00;
      ram1[0] = 8'h01; ram1[1] = 8'h02; ram1[2] = 8'h07; ram1[3] = 8'h06;

      resetN = 1'b0; start = 1'b0; abort = 1'b0; tdo = 1'b1;
      length = '0; tckHalf = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset.tck", tck, 1'b0);
      checkOutput("reset.tms", tms, 1'b1);
      checkOutput("reset.tdi", tdi, 1'b0);
      checkOutput("reset.busy", busy, 1'b0);
      checkOutput("reset.done", done, 1'b0);
      checkOutput("reset.we", vector2We, 1'b0);
      checkOutput("reset.addr1", vector1Addr, 0);
      checkOutput("reset.addr2", vector2Addr, 0);
      checkOutput("reset.wrData", vector2WrData, 8'h00);
      checkOutput("reset.misCnt", mismatchCnt, 0);
      resetN = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] basic run: 4 vectors, tck_half=2");
      r0 = riseCount; h0 = highQ.size(); t0 = tmsQ.size();
      applyStimulus(13'd4, 16'd2);
      checkOutput("basic.busyAfterStart", busy, 1'b1);
      waitDone(200, n);
      checkOutput("basic.doneCycle", n, 28);
      @(negedge clk);
      checkOutput("basic.donePulse", done, 1'b0);
      checkOutput("basic.busyAfter", busy, 1'b0);
      checkOutput("basic.tckIdle", tck, 1'b0);
      checkOutput("basic.tmsHold", tms, 1'b0);
      checkOutput("basic.tdiHold", tdi, 1'b1);
      checkOutput("basic.tckPulses", riseCount - r0, 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("basic.tms%0d", i), tmsQ[t0+i], expTms[i]);
         checkOutput($sformatf("basic.tdi%0d", i), tdiQ[t0+i], expTdi[i]);
         checkOutput($sformatf("basic.high%0d", i), highQ[h0+i], 2);
      end
      for (int i = 1; i < 4; i++)
         checkOutput($sformatf("basic.lowGap%0d", i), lowQ[t0+i], 5);
      checkOutput("basic.ram2_0", ram2[0], 8'h00);
      checkOutput("basic.ram2_1", ram2[1], 8'h00);
      checkOutput("basic.ram2_2", ram2[2], exp2);
      checkOutput("basic.ram2_3", ram2[3], exp3);
      checkOutput("basic.misCnt", mismatchCnt, expMis1);

      $display("[TB] zero length and ignored start");
      r0 = riseCount; w0 = weCount;
      applyStimulus(13'd0, 16'd2);
      waitDone(20, n);
      checkOutput("zero.doneCycle", n, 0);
      checkOutput("zero.busy", busy, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("zero.noTck", riseCount - r0, 0);
      checkOutput("zero.noWrite", weCount - w0, 0);

      w0 = weCount;
      applyStimulus(13'd2, 16'd1);
      repeat (2) @(negedge clk);
      length = 13'd1; tckHalf = 16'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(100, n);
      checkOutput("ignored.doneCycle", n + 3, 10);
      repeat (6) @(negedge clk);
      checkOutput("ignored.writes", weCount - w0, 2);
      checkOutput("ignored.idle", busy, 1'b0);

      $display("[TB] abort during third HIGH phase");
      r0 = riseCount; w0 = weCount; d0 = doneCount;
      applyStimulus(13'd10, 16'd3);
      n = 0;
      while (riseCount - r0 < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("abort.inHigh", tck, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort.tck", tck, 1'b0);
      checkOutput("abort.busy", busy, 1'b0);
      checkOutput("abort.done", done, 1'b0);
      repeat (20) @(negedge clk);
      checkOutput("abort.noDone", doneCount - d0, 0);
      checkOutput("abort.writes", weCount - w0, 2);
      checkOutput("abort.lastAddr", lastWrAddr, 1);
      checkOutput("abort.pulses", riseCount - r0, 3);
      checkOutput("abort.tmsHold", tms, 1'b1);
      checkOutput("abort.tdiHold", tdi, 1'b1);

      $display("[TB] tck_half clamp and full length");
      h0 = highQ.size(); t0 = lowQ.size();
      applyStimulus(13'd3, 16'd0);
      waitDone(100, n);
      checkOutput("clamp.doneCycle", n, 15);
      @(negedge clk);
      checkOutput("clamp.high", highQ[h0+2], 1);
      checkOutput("clamp.lowGap", lowQ[t0+2], 4);

      w0 = weCount; s0 = wrAddrSum;
      applyStimulus(13'd4096, 16'd0);
      waitDone(21000, n);
      checkOutput("full.doneCycle", n, 20480);
      @(negedge clk);
      checkOutput("full.writes", weCount - w0, 4096);
      checkOutput("full.addrSum", wrAddrSum - s0, 64'd8386560);
      checkOutput("full.lastAddr", lastWrAddr, 4095);

      $display("[TB] TDO compare vectors");
      ram1[0] = 8'h0C; ram1[1] = 8'h04; ram1[2] = 8'h0C;
      tdo = 1'b0;
      repeat (3) @(negedge clk);
      applyStimulus(13'd3, 16'd1);
      waitDone(100, n);
      checkOutput("cmp.doneCycle", n, 15);
      @(negedge clk);
      checkOutput("cmp.ram2_0", ram2[0], expCmp0);
      checkOutput("cmp.ram2_1", ram2[1], expCmp1);
      checkOutput("cmp.ram2_2", ram2[2], expCmp0);
      checkOutput("cmp.misCnt", mismatchCnt, expMis6);

      $display("[TB] asynchronous reset in LOW");
      applyStimulus(13'd2, 16'd4);
      repeat (2) @(negedge clk);
      checkOutput("areset.busyBefore", busy, 1'b1);
      checkOutput("areset.tmsBefore", tms, 1'b0);
      #2 resetN = 1'b0;
      #1;
      checkOutput("areset.tck", tck, 1'b0);
      checkOutput("areset.tms", tms, 1'b1);
      checkOutput("areset.busy", busy, 1'b0);
      checkOutput("areset.misCnt", mismatchCnt, 0);
      @(negedge clk);
      resetN = 1'b1;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
